// File: rtl/vid_timing_pattern_gen_if.sv
// Video input bus toward the SiI9136: data enable, syncs and {R,G,B} pixel.
interface vid_timing_pattern_gen_if #(
    parameter int CHAN_BITS = 12
) ();
    logic                   de;
    logic                   hsync;
    logic                   vsync;
    logic [3*CHAN_BITS-1:0] d;

    modport master (output de, hsync, vsync, d);
    modport slave  (input  de, hsync, vsync, d);
endinterface

// File: rtl/vid_timing_pattern_gen.sv
// Programmable video timing generator with four test patterns.
// Every output is registered and aligned, one cycle behind the col/line counters.
module vid_timing_pattern_gen #(
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int H_ACTIVE   = 640,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int V_ACTIVE   = 480,
    parameter int HSYNC_POL  = 1,
    parameter int VSYNC_POL  = 1,
    parameter int CHAN_BITS  = 12,
    parameter int CNT_BITS   = 12,
    parameter int CHECK_LOG2 = 5
) (
    input  logic                     vid_clk,
    input  logic                     vid_reset,
    input  logic                     enable,
    input  logic [1:0]               pattern_mode,
    input  logic [3*CHAN_BITS-1:0]   solid_color,
    vid_timing_pattern_gen_if.master vid,
    output logic                     frame_start
);
    localparam int C     = CHAN_BITS;
    localparam int W     = 3 * CHAN_BITS;
    localparam int HB    = H_FRONT + H_SYNC + H_BACK;
    localparam int VB    = V_FRONT + V_SYNC + V_BACK;
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    localparam logic [CNT_BITS-1:0] ONE_C = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] HB_C  = CNT_BITS'(HB);
    localparam logic [CNT_BITS-1:0] VB_C  = CNT_BITS'(VB);
    localparam logic [CNT_BITS-1:0] HT_M1 = CNT_BITS'(HB + H_ACTIVE - 1);
    localparam logic [CNT_BITS-1:0] VT_M1 = CNT_BITS'(VB + V_ACTIVE - 1);
    localparam logic [CNT_BITS-1:0] VA_M1 = CNT_BITS'(V_ACTIVE - 1);
    localparam logic [CNT_BITS-1:0] HS_LO = CNT_BITS'(H_FRONT);
    localparam logic [CNT_BITS-1:0] HS_HI = CNT_BITS'(H_FRONT + H_SYNC);
    localparam logic [CNT_BITS-1:0] VS_LO = CNT_BITS'(V_FRONT);
    localparam logic [CNT_BITS-1:0] VS_HI = CNT_BITS'(V_FRONT + V_SYNC);
    localparam logic [CNT_BITS-1:0] BW_M1 = CNT_BITS'(BAR_W - 1);
    localparam logic [C-1:0]        ONES  = {C{1'b1}};
    localparam logic                HP    = (HSYNC_POL != 0);
    localparam logic                VP    = (VSYNC_POL != 0);

    logic [CNT_BITS-1:0] col_q, col_d, line_q, line_d;
    logic [CNT_BITS-1:0] off_q, off_d, bcnt_q, bcnt_d;
    logic [2:0]          bar_q, bar_d;
    logic [1:0]          mode_q, mode_d;
    logic [W-1:0]        solid_q, solid_d, d_q, d_d;
    logic                run_q, run_d, de_q, de_d;
    logic                hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;

    logic         origin, h_end, v_end, act, advance;
    logic [C-1:0] x, y;
    logic [W-1:0] pix;

    always_comb begin
        origin  = (col_q == '0) && (line_q == '0);
        h_end   = (col_q == HT_M1);
        v_end   = (line_q == VT_M1);
        act     = (line_q >= VB_C) && (col_q >= HB_C);
        x       = C'(col_q - HB_C);
        y       = C'(line_q - VB_C);
        // run_q marks the current counter value as a counted cycle
        advance = enable && run_q;
        run_d   = enable;

        col_d  = col_q;
        line_d = line_q;
        off_d  = off_q;
        if (!advance) begin
            col_d  = '0;
            line_d = '0;
        end else if (!h_end) begin
            col_d = col_q + ONE_C;
        end else begin
            col_d = '0;
            if (v_end) begin
                line_d = '0;
                off_d  = (off_q == VA_M1) ? '0 : off_q + ONE_C;
            end else begin
                line_d = line_q + ONE_C;
            end
        end

        mode_d  = mode_q;
        solid_d = solid_q;
        if (run_q && origin) begin
            mode_d  = pattern_mode;
            solid_d = solid_color;
        end

        bcnt_d = bcnt_q;
        bar_d  = bar_q;
        if (!act) begin
            bcnt_d = '0;
            bar_d  = '0;
        end else if (bcnt_q == BW_M1) begin
            bcnt_d = '0;
            bar_d  = (bar_q == 3'd7) ? 3'd7 : bar_q + 3'd1;
        end else begin
            bcnt_d = bcnt_q + ONE_C;
        end

        pix = '0;
        unique case (mode_q)
            2'd0: begin
                if (CNT_BITS'(y) < off_q)
                    pix = {ONES, C'(y << 3), C'(x << 3)};
                else
                    pix = {C'(y << 3), ONES, C'(x << 3)};
            end
            2'd1: pix = {{C{~bar_q[1]}}, {C{~bar_q[2]}}, {C{~bar_q[0]}}};
            2'd2: pix = solid_q;
            2'd3: pix = (x[CHECK_LOG2] ^ y[CHECK_LOG2]) ? {W{1'b1}} : '0;
        endcase

        de_d = 1'b0;
        d_d  = '0;
        hs_d = ~HP;
        vs_d = ~VP;
        fs_d = 1'b0;
        if (run_q) begin
            de_d = act;
            d_d  = act ? pix : '0;
            hs_d = (col_q >= HS_LO && col_q < HS_HI) ? HP : ~HP;
            vs_d = (line_q >= VS_LO && line_q < VS_HI) ? VP : ~VP;
            fs_d = origin;
        end
    end

    always_ff @(posedge vid_clk or posedge vid_reset) begin
        if (vid_reset) begin
            col_q   <= '0;
            line_q  <= '0;
            off_q   <= '0;
            bcnt_q  <= '0;
            bar_q   <= '0;
            mode_q  <= '0;
            solid_q <= '0;
            run_q   <= 1'b0;
            de_q    <= 1'b0;
            d_q     <= '0;
            hs_q    <= ~HP;
            vs_q    <= ~VP;
            fs_q    <= 1'b0;
        end else begin
            col_q   <= col_d;
            line_q  <= line_d;
            off_q   <= off_d;
            bcnt_q  <= bcnt_d;
            bar_q   <= bar_d;
            mode_q  <= mode_d;
            solid_q <= solid_d;
            run_q   <= run_d;
            de_q    <= de_d;
            d_q     <= d_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            fs_q    <= fs_d;
        end
    end

    assign vid.de      = de_q;
    assign vid.hsync   = hs_q;
    assign vid.vsync   = vs_q;
    assign vid.d       = d_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_vid_timing_pattern_gen.sv
// Scoreboard bench: a cycle model pushes expected outputs, tasks pop and compare.
module tb_vid_timing_pattern_gen;
    localparam int C = 4;
    localparam int W = 12;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic [1:0]   pattern_mode;
    logic [W-1:0] solid_color;
    logic         fs_p, fs_n;

    vid_timing_pattern_gen_if #(.CHAN_BITS(C)) vp ();
    vid_timing_pattern_gen_if #(.CHAN_BITS(C)) vn ();

    vid_timing_pattern_gen #(
        .H_FRONT(2), .H_SYNC(2), .H_BACK(2), .H_ACTIVE(8),
        .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .V_ACTIVE(4),
        .HSYNC_POL(1), .VSYNC_POL(1), .CHAN_BITS(C),
        .CNT_BITS(12), .CHECK_LOG2(1)
    ) dut_p (
        .vid_clk(clk), .vid_reset(rst), .enable(enable),
        .pattern_mode(pattern_mode), .solid_color(solid_color),
        .vid(vp.master), .frame_start(fs_p)
    );

    vid_timing_pattern_gen #(
        .H_FRONT(2), .H_SYNC(2), .H_BACK(2), .H_ACTIVE(8),
        .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .V_ACTIVE(4),
        .HSYNC_POL(0), .VSYNC_POL(0), .CHAN_BITS(C),
        .CNT_BITS(12), .CHECK_LOG2(1)
    ) dut_n (
        .vid_clk(clk), .vid_reset(rst), .enable(enable),
        .pattern_mode(pattern_mode), .solid_color(solid_color),
        .vid(vn.master), .frame_start(fs_n)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         de;
        logic         hs;
        logic         vs;
        logic         fs;
        logic [W-1:0] d;
    } out_t;

    out_t sb[$];
    out_t exp_o;
    out_t obs;
    assign obs = {vp.de, vp.hsync, vp.vsync, fs_p, vp.d};

    int checks = 0;
    int errors = 0;

    int           m_col, m_line, m_off, m_mode;
    bit           m_en;
    logic [W-1:0] m_solid;
    logic [W-1:0] bars [8];

    initial begin
        bars[0] = 12'hFFF; bars[1] = 12'hFF0;
        bars[2] = 12'h0FF; bars[3] = 12'h0F0;
        bars[4] = 12'hF0F; bars[5] = 12'hF00;
        bars[6] = 12'h00F; bars[7] = 12'h000;
    end

    task automatic model_reset();
        m_col = 0; m_line = 0; m_off = 0;
        m_mode = 0; m_en = 0; m_solid = '0;
    endtask

    // Expected output for the current model cycle, then advance the model.
    task automatic model_push();
        out_t e;
        int x, y;
        logic [3:0] xs, ys;
        e = '0;
        if (m_en) begin
            if (m_col == 0 && m_line == 0) begin
                m_mode  = int'(pattern_mode);
                m_solid = solid_color;
            end
            e.de = (m_line >= 3 && m_col >= 6);
            e.hs = (m_col == 2 || m_col == 3);
            e.vs = (m_line == 1);
            e.fs = (m_col == 0 && m_line == 0);
            if (e.de) begin
                x  = m_col - 6;
                y  = m_line - 3;
                xs = 4'((x * 8) % 16);
                ys = 4'((y * 8) % 16);
                case (m_mode)
                    0: e.d = (y < m_off) ? {4'hF, ys, xs} : {ys, 4'hF, xs};
                    1: e.d = bars[(x > 7) ? 7 : x];
                    2: e.d = m_solid;
                    default: e.d = ((((x / 2) ^ (y / 2)) % 2) == 1) ? 12'hFFF : 12'h000;
                endcase
            end
        end
        if (enable && m_en) begin
            if (m_col == 13) begin
                m_col = 0;
                if (m_line == 6) begin
                    m_line = 0;
                    m_off  = (m_off + 1) % 4;
                end else begin
                    m_line++;
                end
            end else begin
                m_col++;
            end
        end else begin
            m_col = 0;
            m_line = 0;
        end
        m_en = enable;
        sb.push_back(e);
    endtask

    task automatic step();
        model_push();
        @(posedge clk);
        @(negedge clk);
        exp_o = sb.pop_front();
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0;
        pattern_mode = 2'd0; solid_color = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_out got %h want %h", obs, out_t'('0));
        end
        checks++;
        if ({vn.hsync, vn.vsync, fs_n, vn.de} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_neg_pol got %b want 1100",
                     {vn.hsync, vn.vsync, fs_n, vn.de});
        end
        rst = 1'b0;
    endtask

    task automatic test_timing();
        int last_fs, de_cnt, hs_cnt, vs_cnt, nfs;
        last_fs = -1; de_cnt = 0; hs_cnt = 0; vs_cnt = 0; nfs = 0;
        enable = 1'b1;
        pattern_mode = 2'd0;
        for (int i = 0; i < 300; i++) begin
            step();
            checks++;
            if (obs !== exp_o) begin
                errors++;
                $display("FAIL timing cyc %0d got %h want %h", i, obs, exp_o);
            end
            if (obs.fs === 1'b1) begin
                nfs++;
                if (last_fs >= 0) begin
                    checks++;
                    if (i - last_fs != 98 || de_cnt != 32 ||
                        hs_cnt != 14 || vs_cnt != 14) begin
                        errors++;
                        $display("FAIL frame_stats got per=%0d de=%0d hs=%0d vs=%0d want 98 32 14 14",
                                 i - last_fs, de_cnt, hs_cnt, vs_cnt);
                    end
                end
                last_fs = i; de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
            end
            if (obs.de === 1'b1) de_cnt++;
            if (obs.hs === 1'b1) hs_cnt++;
            if (obs.vs === 1'b1) vs_cnt++;
        end
        checks++;
        if (nfs != 4) begin
            errors++;
            $display("FAIL fs_count got %0d want 4", nfs);
        end
    endtask

    task automatic test_pattern(input logic [1:0] mode, input int frames);
        pattern_mode = mode;
        for (int i = 0; i < frames * 98; i++) begin
            step();
            checks++;
            if (obs !== exp_o) begin
                errors++;
                $display("FAIL mode%0d cyc %0d got %h want %h", mode, i, obs, exp_o);
            end
        end
    endtask

    task automatic test_mode_latch();
        int n, solid_cnt;
        n = 0; solid_cnt = 0;
        while (!(m_line == 4 && m_col == 0) && n < 200) begin
            step();
            checks++;
            if (obs !== exp_o) begin
                errors++;
                $display("FAIL latch_pre got %h want %h", obs, exp_o);
            end
            n++;
        end
        pattern_mode = 2'd2;
        solid_color = 12'h5A3;
        for (int i = 0; i < 160; i++) begin
            step();
            checks++;
            if (obs !== exp_o) begin
                errors++;
                $display("FAIL latch cyc %0d got %h want %h", i, obs, exp_o);
            end
            if (obs.de === 1'b1 && obs.d === 12'h5A3) solid_cnt++;
        end
        checks++;
        if (solid_cnt != 32) begin
            errors++;
            $display("FAIL latch_solid_cnt got %0d want 32", solid_cnt);
        end
    endtask

    task automatic test_polarity();
        for (int i = 0; i < 98; i++) begin
            step();
            checks++;
            if ({vn.de, vn.hsync, vn.vsync, fs_n, vn.d} !==
                {exp_o.de, ~exp_o.hs, ~exp_o.vs, exp_o.fs, exp_o.d}) begin
                errors++;
                $display("FAIL polarity cyc %0d got %b%b%b%b want %b%b%b%b", i,
                         vn.de, vn.hsync, vn.vsync, fs_n,
                         exp_o.de, ~exp_o.hs, ~exp_o.vs, exp_o.fs);
            end
        end
    endtask

    task automatic test_enable();
        int n, fs_at;
        n = 0; fs_at = -1;
        pattern_mode = 2'd0;
        while (!(m_en && m_line == 4 && m_col == 9) && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL enable_reach timeout after %0d cycles", n);
        end
        enable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (obs !== exp_o) begin
                errors++;
                $display("FAIL disable cyc %0d got %h want %h", i, obs, exp_o);
            end
        end
        enable = 1'b1;
        for (int i = 0; i < 120; i++) begin
            step();
            checks++;
            if (obs !== exp_o) begin
                errors++;
                $display("FAIL reenable cyc %0d got %h want %h", i, obs, exp_o);
            end
            if (fs_at < 0 && obs.fs === 1'b1) fs_at = i;
        end
        checks++;
        if (fs_at != 1) begin
            errors++;
            $display("FAIL reenable_fs got %0d want 1", fs_at);
        end
    endtask

    task automatic test_async_reset();
        int n;
        n = 0;
        while (!(m_en && m_line == 3 && m_col == 8) && n < 200) begin
            step();
            n++;
        end
        step();
        checks++;
        if (obs.de !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre de got %b want 1", obs.de);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== '0 || vn.hsync !== 1'b1 || vn.vsync !== 1'b1) begin
            errors++;
            $display("FAIL areset_idle got %h nhs %b nvs %b want 0 1 1",
                     obs, vn.hsync, vn.vsync);
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            checks++;
            if (obs !== exp_o) begin
                errors++;
                $display("FAIL post_reset cyc %0d got %h want %h", i, obs, exp_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_pattern(2'd1, 2);
        test_pattern(2'd3, 2);
        test_mode_latch();
        test_pattern(2'd0, 5);
        test_polarity();
        test_enable();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
